// File: rtl/snake_game_ctrl.sv
// rtl/snake_game_ctrl.sv - game FSM, step pacing, direction arbitration and spawn cells for the snake engine
module snake_game_ctrl #(
  parameter int unsigned TICK_DIV = 5000000,
  parameter int unsigned SPEEDUP  = 250000,
  parameter int unsigned MIN_DIV  = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn_up_n,
  input  logic       i_btn_down_n,
  input  logic       i_btn_left_n,
  input  logic       i_btn_right_n,
  input  logic       i_start,
  input  logic       i_pause,
  input  logic [3:0] i_score,
  input  logic       i_dead,
  input  logic       i_win,
  output logic       o_dir_up,
  output logic       o_dir_down,
  output logic       o_dir_left,
  output logic       o_dir_right,
  output logic       o_step,
  output logic       o_engine_rst_n,
  output logic [7:0] o_spawn_apple,
  output logic [7:0] o_spawn_barrier,
  output logic [2:0] o_state
);

  localparam logic [31:0] L_TICK  = 32'(TICK_DIV);
  localparam logic [31:0] L_SPEED = 32'(SPEEDUP);
  localparam logic [31:0] L_MIN   = 32'(MIN_DIV);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_OVER  = 3'd3,
    S_WIN   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // Direction vectors are one-hot as {right, left, down, up}.
  logic [3:0]  w_btn_n;
  logic [3:0]  r_btn_s1;
  logic [3:0]  r_btn_s2;
  logic [3:0]  r_btn_d;
  logic [3:0]  w_press;
  logic [3:0]  w_sel;
  logic [3:0]  w_rev;
  logic        w_accept;
  logic [3:0]  r_pend;
  logic [3:0]  r_dir;
  logic [3:0]  w_dir_out;
  logic        w_restart;

  logic [31:0] w_sub;
  logic [31:0] w_div;
  logic [31:0] r_div;
  logic [31:0] r_cnt;
  logic        w_term;
  logic        w_step;

  logic [7:0]  r_lfsr;
  logic        w_fb;
  logic [7:0]  w_cand_a;
  logic [7:0]  w_cand_b;
  logic [7:0]  r_apple;
  logic [7:0]  r_barrier;

  // Interior cell: row 1..8 from x[2:0], column 2..9 from x[5:3], encoded row*10+col.
  function automatic logic [7:0] f_cell(input logic [5:0] x);
    f_cell = 8'd10 * ({5'd0, x[2:0]} + 8'd1) + {5'd0, x[5:3]} + 8'd2;
  endfunction

  assign w_btn_n = {i_btn_right_n, i_btn_left_n, i_btn_down_n, i_btn_up_n};

  // Two-flop synchronizer plus one delay stage for falling-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_btn_s1 <= 4'hF;
      r_btn_s2 <= 4'hF;
      r_btn_d  <= 4'hF;
    end else begin
      r_btn_s1 <= w_btn_n;
      r_btn_s2 <= r_btn_s1;
      r_btn_d  <= r_btn_s2;
    end
  end

  assign w_press = r_btn_d & ~r_btn_s2;

  // Pick one press (up > down > left > right) and reject a reversal of the committed heading.
  always_comb begin
    w_sel = 4'b0000;
    if (w_press[0])      w_sel = 4'b0001;
    else if (w_press[1]) w_sel = 4'b0010;
    else if (w_press[2]) w_sel = 4'b0100;
    else if (w_press[3]) w_sel = 4'b1000;
    w_rev    = {r_dir[2], r_dir[3], r_dir[0], r_dir[1]};
    w_accept = (r_state == S_RUN) && (w_sel != 4'b0000) && (w_sel != w_rev);
  end

  // Step period shrinks with score, floored at MIN_DIV; registered to keep the multiply off the compare path.
  always_comb begin
    w_sub = {28'd0, i_score} * L_SPEED;
    if ((w_sub < L_TICK) && ((L_TICK - w_sub) > L_MIN)) w_div = L_TICK - w_sub;
    else                                                 w_div = L_MIN;
  end

  // Holds the current step period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_div <= L_TICK;
    else      r_div <= w_div;
  end

  // ">=" lets a freshly shortened period wrap an over-range count on the next compare.
  assign w_term = (r_cnt >= (r_div - 32'd1));
  assign w_step = (r_state == S_RUN) && w_term;

  // Step counter: runs in RUN, frozen in PAUSE (including the cycle pause is taken), cleared otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 32'd0;
    end else if (r_state == S_RUN) begin
      if (w_term)                   r_cnt <= 32'd0;
      else if (w_state_nxt == S_RUN) r_cnt <= r_cnt + 32'd1;
    end else if (r_state != S_PAUSE) begin
      r_cnt <= 32'd0;
    end
  end

  // Game FSM next state; dead beats win, pause is only meaningful in RUN/PAUSE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_RUN;
      S_RUN: begin
        if (i_dead)       w_state_nxt = S_OVER;
        else if (i_win)   w_state_nxt = S_WIN;
        else if (i_pause) w_state_nxt = S_PAUSE;
      end
      S_PAUSE: begin
        if (i_dead)       w_state_nxt = S_OVER;
        else if (i_win)   w_state_nxt = S_WIN;
        else if (i_pause) w_state_nxt = S_RUN;
      end
      S_OVER:  if (i_start) w_state_nxt = S_IDLE;
      S_WIN:   if (i_start) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  assign w_restart = ((r_state == S_OVER) || (r_state == S_WIN)) && i_start;

  // Pending slot takes the latest accepted press; it commits on the step cycle (a press on that cycle is dropped).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dir  <= 4'b0000;
      r_pend <= 4'b0000;
    end else if (w_restart) begin
      r_dir  <= 4'b0000;
      r_pend <= 4'b0000;
    end else if (w_step) begin
      if (r_pend != 4'b0000) r_dir <= r_pend;
      r_pend <= 4'b0000;
    end else if (w_accept) begin
      r_pend <= w_sel;
    end
  end

  // The engine sees the new heading in the same cycle it sees the step.
  assign w_dir_out = (w_step && (r_pend != 4'b0000)) ? r_pend : r_dir;

  assign w_fb     = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_cand_a = f_cell(r_lfsr[5:0]);
  assign w_cand_b = f_cell({r_lfsr[7:6], r_lfsr[0], r_lfsr[5:3]});

  // Free-running LFSR and spawn cells; barrier only moves when it would not land on the apple.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr    <= 8'hB5;
      r_apple   <= 8'd12;
      r_barrier <= 8'd89;
    end else begin
      r_lfsr  <= {r_lfsr[6:0], w_fb};
      r_apple <= w_cand_a;
      if (w_cand_b != w_cand_a) r_barrier <= w_cand_b;
    end
  end

  assign o_dir_up        = w_dir_out[0];
  assign o_dir_down      = w_dir_out[1];
  assign o_dir_left      = w_dir_out[2];
  assign o_dir_right     = w_dir_out[3];
  assign o_step          = w_step;
  assign o_engine_rst_n  = (r_state != S_IDLE);
  assign o_spawn_apple   = r_apple;
  assign o_spawn_barrier = r_barrier;
  assign o_state         = r_state;

endmodule

// File: doc/snake_game_ctrl.md
Name: snake_game_ctrl

Overview:
Game-level controller that sequences the snake engine.
- Runs the game FSM (idle/run/pause/over/win).
- Generates the step strobe that advances the engine, with speed ramping up as score rises.
- Arbitrates the four direction buttons into one committed one-hot direction, rejecting 180° reversals.
- Supplies spawn cells for apple and barrier from an on-chip LFSR.

Parameters:
- TICK_DIV, 5000000: clk cycles per step at score 0.
- SPEEDUP, 250000: cycles removed from the step period per score point.
- MIN_DIV, 1000000: floor on the step period.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- btn_up_n, btn_down_n, btn_left_n, btn_right_n  in  1 each  raw active-low buttons
- start  in  1  one-cycle start/restart pulse
- pause  in  1  one-cycle pause-toggle pulse
- score_in  in  4  engine score
- dead_in  in  1  engine dead flag
- win_in  in  1  engine win flag
- dir_up, dir_down, dir_left, dir_right  out  1 each  committed direction, one-hot or all-zero
- step  out  1  one-cycle engine advance strobe
- engine_rst_n  out  1  engine reset, active-low
- spawn_apple  out  8  apple cell, row*10+col
- spawn_barrier  out  8  barrier cell, row*10+col
- state  out  3  FSM state code

Behaviour:

Reset (rst low, asynchronous; also applies mid-game):
- FSM to IDLE; step=0; engine_rst_n=0; all dir_* = 0; pending direction cleared.
- Tick counter = 0; LFSR = 8'hB5.
- spawn_apple = 8'd12; spawn_barrier = 8'd89.

Button input path:
- Each btn_*_n passes through a 2-FF synchronizer, then falling-edge detect, giving a one-cycle press.
- Presses are accepted only in RUN.
- Same-cycle priority: up > down > left > right.
- A press equal to the reverse of the committed direction is discarded (up/down, left/right pairs).
- An accepted press overwrites the single pending slot; the latest accepted press wins.

Direction commit:
- On the step cycle, a valid pending direction moves to dir_* in the same cycle step is high, and pending clears.
- dir_* is therefore stable between steps.
- While committed direction is none, any first press is accepted.

Step timing:
- Period div = max(MIN_DIV, TICK_DIV - score_in*SPEEDUP), computed at 32-bit width, with subtraction saturating at MIN_DIV.
- Counter counts 0..div-1 in RUN; step=1 on the cycle the counter equals div-1, then the counter returns to 0.
- If div shrinks below the current count, the counter wraps at the next compare (>= div-1 treated as terminal).
- Counter frozen in PAUSE; cleared in IDLE/OVER/WIN.

FSM (state codes IDLE=0, RUN=1, PAUSE=2, OVER=3, WIN=4):
- IDLE: engine_rst_n=0; start -> RUN (engine_rst_n=1 from the next cycle; first step after div cycles).
- RUN:
  - dead_in=1 -> OVER.
  - else win_in=1 -> WIN (dead has priority if both are high).
  - else pause -> PAUSE.
  - start ignored.
- PAUSE: pause -> RUN; dead_in/win_in still take OVER/WIN with the same priority; no step.
- OVER/WIN: no step; dir_* held; start -> IDLE with dir_* cleared.
- Simultaneous start and pause: start evaluated first in IDLE/OVER/WIN; pause evaluated first in RUN/PAUSE.

Spawn generation:
- LFSR: 8-bit Fibonacci, taps 8,6,5,4; advances every clk in all states.
- Candidate A = 10*(1+lfsr[2:0]) + (2+lfsr[5:3]), range 12..89, rows 1..8, cols 2..9.
- Candidate B is the same mapping applied to {lfsr[7:6],lfsr[0],lfsr[5:3]}.
- spawn_apple loads A every cycle.
- spawn_barrier loads B only when B != A; otherwise it holds.
- Guaranteed: spawn_apple != spawn_barrier whenever B updated in the same cycle; both always in the legal interior.

Test Plan:
(All scenarios use TICK_DIV=10, SPEEDUP=2, MIN_DIV=4.)
- Reset then start pulse -> state=1, engine_rst_n=1; first step exactly 10 cycles later, then every 10 cycles; dir_* all 0.
- Cadence: score_in=2 -> step period 6; score_in=5 -> period 4 (floor held); score changed mid-count from 0 to 4 at count 7 -> step on the next cycle, then period 4.
- Directions:
  - Press up then right within one period -> at the next step dir_right=1 only.
  - With dir_right committed, press left -> ignored, dir_right held.
  - Up and left asserted in the same cycle -> up taken.
- Pause:
  - Pause at count 3 -> no step for 50 cycles, counter held at 3.
  - Second pause -> step after 6 more cycles.
  - Buttons pressed while paused are not committed.
- End states:
  - dead_in=1 and win_in=1 together in RUN -> state=3, no further step.
  - Start -> state=0, engine_rst_n=0, dir_* cleared.
- Spawn and reset:
  - Over 1000 cycles: every spawn_apple/spawn_barrier value has tens digit 1..8 and units digit 2..9, and spawn_barrier != spawn_apple on every cycle it updates.
  - rst low mid-RUN -> all outputs at reset values within the same cycle.
